// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction-cache refill path.
package icache_pkg;

  localparam logic [2:0]  LINE_WORDS = 3'd4;
  localparam int          WORD_W     = 32;
  localparam int          LINE_W     = 128;
  localparam int          LINE_OFF_W = 4;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RESP
  } refill_state_e;

  // Byte address of word idx within the line starting at base.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [2:0] idx);
    return base + {27'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/icache_refill_timer.sv
// Idle watchdog for a line fill: counts cycles without bus progress and flags expiry.
module icache_refill_timer
  import icache_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic activity,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] idle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (!run || activity) begin
      idle_cnt <= '0;
    end else if (idle_cnt != 16'hFFFF) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  assign expired = run && (idle_cnt >= LIMIT);

endmodule

// File: rtl/icache_refill_bridge.sv
// Refill engine: turns one 16-byte line miss into four pipelined 32-bit bus reads.
// Optional abort-on-stall watchdog compiled in with ICACHE_REFILL_TIMEOUT_EN.
module icache_refill_bridge
  import icache_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid_i,
  input  logic [31:0]   req_addr_i,
  output logic          line_ready_o,
  output logic [127:0]  line_data_o,
  output logic          line_err_o,
  output logic          bus_req_o,
  output logic [31:0]   bus_addr_o,
  input  logic          bus_gnt_i,
  input  logic          bus_rvalid_i,
  input  logic [31:0]   bus_rdata_i
);

  refill_state_e state;
  logic [31:0]   base;
  logic [2:0]    issue_cnt;
  logic [2:0]    recv_cnt;
  logic [2:0]    issue_next;
  logic [2:0]    recv_next;
  logic          gnt_fire;
  logic          rvalid_fire;
  logic          abort;
  logic [31:0]   req_base;

  assign req_base    = {req_addr_i[31:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
  assign gnt_fire    = (state == FILL) && bus_req_o && bus_gnt_i;
  // A response is only meaningful while a read is outstanding.
  assign rvalid_fire = (state == FILL) && bus_rvalid_i && (recv_cnt < issue_cnt);
  assign issue_next  = issue_cnt + {2'b00, gnt_fire};
  assign recv_next   = recv_cnt + {2'b00, rvalid_fire};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      base         <= '0;
      issue_cnt    <= '0;
      recv_cnt     <= '0;
      line_data_o  <= '0;
      line_ready_o <= 1'b0;
      bus_req_o    <= 1'b0;
      bus_addr_o   <= '0;
    end else begin
      line_ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            base        <= req_base;
            issue_cnt   <= '0;
            recv_cnt    <= '0;
            line_data_o <= '0;
            bus_req_o   <= 1'b1;
            bus_addr_o  <= req_base;
            state       <= FILL;
          end
        end
        FILL: begin
          issue_cnt <= issue_next;
          recv_cnt  <= recv_next;
          if (gnt_fire) begin
            bus_req_o <= (issue_next < LINE_WORDS);
            if (issue_next < LINE_WORDS) begin
              bus_addr_o <= word_addr(base, issue_next);
            end
          end
          if (rvalid_fire) begin
            line_data_o[{recv_cnt[1:0], 5'd0} +: WORD_W] <= bus_rdata_i;
          end
          if (recv_next == LINE_WORDS) begin
            line_ready_o <= 1'b1;
            state        <= RESP;
          end else if (abort) begin
            bus_req_o    <= 1'b0;
            line_data_o  <= {4{NOP_INST}};
            line_ready_o <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ICACHE_REFILL_TIMEOUT_EN
  logic expired;

  icache_refill_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (state == FILL),
    .activity (gnt_fire || rvalid_fire),
    .expired  (expired)
  );

  // Progress in the expiry cycle wins, so no granted read is left dangling.
  assign abort = expired && !gnt_fire && !rvalid_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_err_o <= 1'b0;
    end else begin
      line_err_o <= (state == FILL) && (recv_next != LINE_WORDS) && abort;
    end
  end
`else
  logic [31:0] unused_timeout;

  assign abort          = 1'b0;
  assign line_err_o     = 1'b0;
  assign unused_timeout = TIMEOUT_CYCLES;
`endif

  logic [LINE_OFF_W-1:0] unused_addr_off;
  assign unused_addr_off = req_addr_i[LINE_OFF_W-1:0];

endmodule

// File: tb/tb_icache_refill_bridge.sv
// Randomised bench for icache_refill_bridge with a queue-based bus/memory model.
module tb_icache_refill_bridge;

  localparam int TO = 8;

  logic         clk;
  logic         rst_n;
  logic         req_valid_i;
  logic [31:0]  req_addr_i;
  logic         line_ready_o;
  logic [127:0] line_data_o;
  logic         line_err_o;
  logic         bus_req_o;
  logic [31:0]  bus_addr_o;
  logic         bus_gnt_i;
  logic         bus_rvalid_i;
  logic [31:0]  bus_rdata_i;

  icache_refill_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_addr_i   (req_addr_i),
    .line_ready_o (line_ready_o),
    .line_data_o  (line_data_o),
    .line_err_o   (line_err_o),
    .bus_req_o    (bus_req_o),
    .bus_addr_o   (bus_addr_o),
    .bus_gnt_i    (bus_gnt_i),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [31:0] seed;
  logic [127:0] exp_last;

  // Observations from the most recent fill
  logic [31:0]  obs_addr[$];
  int           obs_ready;
  int           obs_ready_cyc;
  logic [127:0] obs_line;
  logic         obs_err;
  logic         obs_req_ready;
  int           obs_req_late;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234 ^ seed;
  endfunction

  function automatic logic [127:0] exp_line(input logic [31:0] addr);
    logic [127:0] r;
    logic [31:0]  b;
    b = {addr[31:4], 4'h0};
    for (int i = 0; i < 4; i++) r[32*i +: 32] = mem_word(b + 32'(4 * i));
    return r;
  endfunction

  // Drives one request and plays memory. gap<0: random grants; lat<0: random latency.
  task automatic run_fill(input logic [31:0] addr, input int gap, input int lat, input int spur_cyc);
    logic [31:0] rq_data[$];
    int          rq_due[$];
    int          wait_cnt;
    int          last_due;
    int          post;
    int          d;
    wait_cnt = 0; last_due = 0; post = 0;
    obs_addr.delete();
    obs_ready = 0; obs_ready_cyc = -1; obs_line = '0; obs_err = 1'b0;
    obs_req_ready = 1'b0; obs_req_late = 0;
    @(posedge clk); #1;
    req_valid_i = 1'b1; req_addr_i = addr; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(posedge clk); #1;
      req_valid_i = (cyc == spur_cyc);
      req_addr_i  = (cyc == spur_cyc) ? (addr ^ 32'h0001_0040) : addr;
      if (line_ready_o) begin
        obs_ready++;
        if (obs_ready == 1) begin
          obs_ready_cyc = cyc; obs_line = line_data_o;
          obs_err = line_err_o; obs_req_ready = bus_req_o;
        end
      end
      if (obs_addr.size() >= 4 && bus_req_o) obs_req_late++;
      bus_gnt_i = 1'b0;
      if (bus_req_o) begin
        if (gap < 0) bus_gnt_i = ($urandom_range(0, 2) != 0);
        else         bus_gnt_i = (wait_cnt >= gap);
        if (bus_gnt_i) begin
          wait_cnt = 0;
          obs_addr.push_back(bus_addr_o);
          if (lat < 0) d = cyc + int'($urandom_range(1, 6));
          else         d = cyc + lat;
          if (d <= last_due) d = last_due + 1;
          last_due = d;
          rq_due.push_back(d);
          rq_data.push_back(mem_word(bus_addr_o));
        end else begin
          wait_cnt++;
        end
      end
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = $urandom;
      if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = rq_data.pop_front();
        void'(rq_due.pop_front());
      end
      if (obs_ready > 0) post++;
      if (post > 4) break;
    end
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; req_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid_i = 1'b0; req_addr_i = '0; bus_gnt_i = 1'b0;
    bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++; if (line_ready_o !== 1'b0) $display("FAIL reset_ready got %b want 0", line_ready_o); else pass_cnt++;
    chk_cnt++; if (line_err_o !== 1'b0) $display("FAIL reset_err got %b want 0", line_err_o); else pass_cnt++;
    chk_cnt++; if (line_data_o !== 128'd0) $display("FAIL reset_data got %h want 0", line_data_o); else pass_cnt++;
    chk_cnt++; if (bus_req_o !== 1'b0) $display("FAIL reset_bus_req got %b want 0", bus_req_o); else pass_cnt++;
    chk_cnt++; if (bus_addr_o !== 32'd0) $display("FAIL reset_bus_addr got %h want 0", bus_addr_o); else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [127:0] exp;
    exp = exp_line(32'h0000_1238);
    run_fill(32'h0000_1238, 0, 1, 0);
    chk_cnt++; if (obs_addr.size() !== 4) $display("FAIL basic_ngrants got %0d want 4", obs_addr.size()); else pass_cnt++;
    for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
      chk_cnt++;
      if (obs_addr[i] !== 32'h0000_1230 + 32'(4 * i))
        $display("FAIL basic_addr%0d got %h want %h", i, obs_addr[i], 32'h0000_1230 + 32'(4 * i));
      else pass_cnt++;
    end
    chk_cnt++; if (obs_line !== exp) $display("FAIL basic_line got %h want %h", obs_line, exp); else pass_cnt++;
    chk_cnt++; if (obs_ready_cyc !== 6) $display("FAIL basic_latency got %0d want 6", obs_ready_cyc); else pass_cnt++;
    chk_cnt++; if (obs_err !== 1'b0) $display("FAIL basic_err got %b want 0", obs_err); else pass_cnt++;
    chk_cnt++; if (obs_ready !== 1) $display("FAIL basic_pulses got %0d want 1", obs_ready); else pass_cnt++;
    exp_last = exp;
  endtask

  task automatic test_backpressure();
    logic [127:0] exp;
    exp = exp_line(32'h8000_0A5C);
    run_fill(32'h8000_0A5C, 3, 5, 0);
    chk_cnt++; if (obs_line !== exp) $display("FAIL bp_line got %h want %h", obs_line, exp); else pass_cnt++;
    chk_cnt++; if (obs_ready !== 1) $display("FAIL bp_pulses got %0d want 1", obs_ready); else pass_cnt++;
    chk_cnt++; if (obs_req_late !== 0) $display("FAIL bp_req_after_4 got %0d want 0", obs_req_late); else pass_cnt++;
    chk_cnt++; if (obs_addr.size() !== 4) $display("FAIL bp_ngrants got %0d want 4", obs_addr.size()); else pass_cnt++;
    exp_last = exp;
  endtask

  task automatic test_overlap();
    logic [127:0] exp;
    exp = exp_line(32'h0040_FFF0);
    // Grants in cycles 1..4, latency 2: word-2 grant and word-0 data share cycle 3.
    run_fill(32'h0040_FFF0, 0, 2, 0);
    chk_cnt++; if (obs_line !== exp) $display("FAIL overlap_line got %h want %h", obs_line, exp); else pass_cnt++;
    chk_cnt++; if (obs_ready_cyc !== 7) $display("FAIL overlap_latency got %0d want 7", obs_ready_cyc); else pass_cnt++;
    chk_cnt++; if (obs_ready !== 1) $display("FAIL overlap_pulses got %0d want 1", obs_ready); else pass_cnt++;
    exp_last = exp;
  endtask

  task automatic test_spurious();
    int seen_req;
    int seen_ready;
    logic [127:0] exp;
    seen_req = 0; seen_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus_req_o) seen_req++;
      if (line_ready_o) seen_ready++;
      bus_rvalid_i = (i < 3);
      bus_rdata_i  = $urandom;
    end
    chk_cnt++; if (seen_req !== 0) $display("FAIL spur_idle_req got %0d want 0", seen_req); else pass_cnt++;
    chk_cnt++; if (seen_ready !== 0) $display("FAIL spur_idle_ready got %0d want 0", seen_ready); else pass_cnt++;
    chk_cnt++; if (line_data_o !== exp_last) $display("FAIL spur_idle_hold got %h want %h", line_data_o, exp_last); else pass_cnt++;
    exp = exp_line(32'h1234_5670);
    run_fill(32'h1234_5670, 0, 1, 2);
    chk_cnt++; if (obs_addr.size() !== 4) $display("FAIL spur_ngrants got %0d want 4", obs_addr.size()); else pass_cnt++;
    chk_cnt++; if (obs_line !== exp) $display("FAIL spur_line got %h want %h", obs_line, exp); else pass_cnt++;
    chk_cnt++; if (obs_ready !== 1) $display("FAIL spur_pulses got %0d want 1", obs_ready); else pass_cnt++;
    seen_req = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus_req_o) seen_req++;
    end
    chk_cnt++; if (seen_req !== 0) $display("FAIL spur_second_fill got %0d want 0", seen_req); else pass_cnt++;
    exp_last = exp;
  endtask

  task automatic test_reset_midfill();
    int seen_req;
    int seen_ready;
    logic [127:0] exp;
    @(posedge clk); #1;
    req_valid_i = 1'b1; req_addr_i = 32'h0000_2000;
    @(posedge clk); #1;
    req_valid_i = 1'b0; bus_gnt_i = 1'b1;
    @(posedge clk); #1;
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEAD_0000;
    @(posedge clk); #1;
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEAD_0001;
    @(posedge clk); #1;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (line_data_o !== 128'd0) $display("FAIL midrst_data got %h want 0", line_data_o); else pass_cnt++;
    chk_cnt++; if (bus_req_o !== 1'b0 || bus_addr_o !== 32'd0)
      $display("FAIL midrst_bus got req=%b addr=%h want 0/0", bus_req_o, bus_addr_o); else pass_cnt++;
    chk_cnt++; if (line_ready_o !== 1'b0 || line_err_o !== 1'b0)
      $display("FAIL midrst_ready got %b/%b want 0/0", line_ready_o, line_err_o); else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_req = 0; seen_ready = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus_req_o) seen_req++;
      if (line_ready_o) seen_ready++;
    end
    chk_cnt++; if (seen_req !== 0 || seen_ready !== 0)
      $display("FAIL midrst_idle got req=%0d ready=%0d want 0/0", seen_req, seen_ready); else pass_cnt++;
    exp = exp_line(32'h0000_2004);
    run_fill(32'h0000_2004, 0, 1, 0);
    chk_cnt++; if (obs_line !== exp) $display("FAIL midrst_refill_line got %h want %h", obs_line, exp); else pass_cnt++;
    chk_cnt++; if (obs_ready_cyc !== 6) $display("FAIL midrst_refill_latency got %0d want 6", obs_ready_cyc); else pass_cnt++;
    exp_last = exp;
  endtask

  task automatic test_random();
    logic [31:0]  a;
    logic [31:0]  b;
    logic [127:0] exp;
    int           bad;
    for (int n = 0; n < 8; n++) begin
      a = $urandom;
      b = {a[31:4], 4'h0};
      exp = exp_line(a);
      run_fill(a, -1, -1, 0);
      bad = 0;
      for (int i = 0; i < obs_addr.size(); i++)
        if (i >= 4 || obs_addr[i] !== b + 32'(4 * i)) bad++;
      if (obs_addr.size() != 4) bad++;
      chk_cnt++; if (bad !== 0) $display("FAIL rand%0d_addrs got %0d bad grants (n=%0d) want 0", n, bad, obs_addr.size()); else pass_cnt++;
      chk_cnt++; if (obs_line !== exp) $display("FAIL rand%0d_line got %h want %h", n, obs_line, exp); else pass_cnt++;
      chk_cnt++; if (obs_ready !== 1 || obs_err !== 1'b0)
        $display("FAIL rand%0d_pulse got %0d err=%b want 1 err=0", n, obs_ready, obs_err); else pass_cnt++;
      exp_last = exp;
    end
  endtask

`ifdef ICACHE_REFILL_TIMEOUT_EN
  task automatic test_timeout();
    run_fill(32'h0000_3000, 100000, 1, 0);
    chk_cnt++; if (obs_ready !== 1) $display("FAIL to_pulses got %0d want 1", obs_ready); else pass_cnt++;
    chk_cnt++; if (obs_err !== 1'b1) $display("FAIL to_err got %b want 1", obs_err); else pass_cnt++;
    chk_cnt++; if (obs_line !== {4{32'h0000_0013}}) $display("FAIL to_line got %h want %h", obs_line, {4{32'h0000_0013}}); else pass_cnt++;
    // TO idle cycles in FILL, then the abort registers
    chk_cnt++; if (obs_ready_cyc < TO + 1 || obs_ready_cyc > TO + 2)
      $display("FAIL to_cycle got %0d want %0d..%0d", obs_ready_cyc, TO + 1, TO + 2); else pass_cnt++;
    chk_cnt++; if (obs_req_ready !== 1'b0) $display("FAIL to_bus_req got %b want 0", obs_req_ready); else pass_cnt++;
  endtask
`endif

  initial begin
    seed = $urandom;
    exp_last = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overlap();
    test_spurious();
    test_reset_midfill();
    test_random();
`ifdef ICACHE_REFILL_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
